// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: pipelined signed MULT, 32-step restoring DIVU/DIV, MTHI/MTLO.
// Define MULDIV_SIGNED_DIV_EN to compile in signed DIV; otherwise op 3'd3 runs as DIVU.
//
// state | meaning
// IDLE  | accepting ops, MTHI/MTLO write HI/LO directly
// MUL   | product in flight, counting down to the HI/LO write
// DIV   | one quotient bit per cycle, iteration count 0..31
module muldiv_ctrl #(
   parameter int MUL_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;

   localparam logic [2:0] OP_MULT = 3'd1;
   localparam logic [2:0] OP_DIVU = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
   localparam logic [5:0] DIV_LAST = 6'd31;

   logic [1:0]  state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] rem_q, rem_d;
`ifdef MULDIV_SIGNED_DIV_EN
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
`endif

   logic [63:0] prod;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] quo_next;
   logic [31:0] rem_next;

   // opa_q doubles as the dividend/quotient shift register during DIV
   always_comb begin
      prod     = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
      shifted  = {rem_q, opa_q[31]};
      trial    = shifted - {1'b0, opb_q};
      quo_next = {opa_q[30:0], ~trial[32]};
      rem_next = trial[32] ? shifted[31:0] : trial[31:0];
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      rem_d   = rem_q;
`ifdef MULDIV_SIGNED_DIV_EN
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (op_valid && !flush) begin
               case (op)
                  OP_MULT: begin
                     opa_d   = op_a;
                     opb_d   = op_b;
                     cnt_d   = MUL_LAST;
                     state_d = ST_MUL;
                  end
                  OP_DIVU: begin
                     opa_d   = op_a;
                     opb_d   = op_b;
                     rem_d   = 32'd0;
                     cnt_d   = 6'd0;
                     state_d = ST_DIV;
`ifdef MULDIV_SIGNED_DIV_EN
                     neg_quo_d = 1'b0;
                     neg_rem_d = 1'b0;
`endif
                  end
                  OP_DIV: begin
`ifdef MULDIV_SIGNED_DIV_EN
                     // divide magnitudes; a zero divisor keeps the raw quotient of all ones
                     opa_d     = op_a[31] ? (32'd0 - op_a) : op_a;
                     opb_d     = op_b[31] ? (32'd0 - op_b) : op_b;
                     neg_quo_d = (op_a[31] ^ op_b[31]) && (op_b != 32'd0);
                     neg_rem_d = op_a[31];
`else
                     opa_d     = op_a;
                     opb_d     = op_b;
`endif
                     rem_d   = 32'd0;
                     cnt_d   = 6'd0;
                     state_d = ST_DIV;
                  end
                  OP_MTHI: hi_d = op_a;
                  OP_MTLO: lo_d = op_a;
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = 6'd0;
            end else if (cnt_q == 6'd0) begin
               hi_d    = prod[63:32];
               lo_d    = prod[31:0];
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         ST_DIV: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = 6'd0;
            end else begin
               opa_d = quo_next;
               rem_d = rem_next;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == DIV_LAST) begin
`ifdef MULDIV_SIGNED_DIV_EN
                  hi_d = neg_rem_q ? (32'd0 - rem_next) : rem_next;
                  lo_d = neg_quo_q ? (32'd0 - quo_next) : quo_next;
`else
                  hi_d = rem_next;
                  lo_d = quo_next;
`endif
                  cnt_d   = 6'd0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         cnt_q   <= 6'd0;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         rem_q   <= 32'd0;
`ifdef MULDIV_SIGNED_DIV_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         rem_q   <= rem_d;
`ifdef MULDIV_SIGNED_DIV_EN
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the HI/LO multiply/divide resource of the CPU execute stage. Accepts MULT/DIVU (and optionally DIV) plus MTHI/MTLO from the decoded instruction stream. Runs a pipelined multiplier or a 32-step radix-2 restoring divider, owns the HI/LO registers and raises `busy` so the pipeline stalls dependent ops and MFHI/MFLO. Sits beside the ALU; its `hi`/`lo` outputs feed the MFHI/MFLO result mux.

## Interface
- `MUL_LATENCY`, default 2: cycles from accept to HI/LO write for multiply; legal range 1..4.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `op_valid` in 1: operation request.
- `op` in 3: 3'd1 MULT, 3'd2 DIVU, 3'd3 DIV, 3'd4 MTHI, 3'd5 MTLO; other codes ignored.
- `op_a` in 32: rs operand (dividend / multiplicand / MTxx data).
- `op_b` in 32: rt operand (divisor / multiplier).
- `flush` in 1: exception abort of an in-flight operation.
- `busy` out 1: controller not idle; upstream must hold the op and stall MFHI/MFLO.
- `done` out 1: one-cycle pulse, HI/LO just written by MULT/DIV.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- FSM states: IDLE, MUL, DIV. `busy` = state != IDLE, registered.
- Accept: `op_valid` with a legal code while IDLE and `flush`=0. `op_valid` while busy is ignored, not queued.
- MTHI/MTLO: write `op_a` into HI/LO at the accept edge; state stays IDLE; no `busy`, no `done`.
- MULT: latch operands and go to MUL. The signed 64-bit product goes to {HI,LO} after MUL_LATENCY cycles, then return to IDLE.
- DIVU: latch operands, clear the remainder accumulator and go to DIV. Run 6-bit iteration count 0..31, one quotient bit per cycle, MSB first. Remainder is 33-bit (trial subtract with borrow bit).
- Division results: LO = quotient, HI = remainder.
- Divide by zero is defined: HI = `op_a`, LO = 32'hFFFF_FFFF, with the full 32 cycles.
- DIV (signed): divide magnitudes. Quotient is negated when the operand signs differ; the remainder takes the dividend's sign. 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0. Signed divide by zero gives HI=`op_a`, LO=32'hFFFF_FFFF.
- `flush` in MUL/DIV: next edge returns to IDLE, HI/LO unchanged, no `done`. `flush` in IDLE blocks acceptance that cycle.
- Reset, including mid-operation: state IDLE, `busy`=0, `done`=0, HI=0, LO=0, counters 0.

## Timing
- Accept at edge E0; `busy`=1 from E0.
- MULT: HI/LO written at edge E0+MUL_LATENCY. `busy`=0 and `done`=1 in the cycle after that edge.
- DIV/DIVU: iterations at edges E0+1..E0+32; HI/LO written at E0+32. `busy` is high for exactly 32 cycles; `done`=1 in the following cycle.
- A new op may be accepted in the same cycle `done`=1 (back-to-back, zero bubble).
- MTHI/MTLO: HI/LO visible the cycle after the accept edge.
- `hi`/`lo` are direct register outputs, never combinational from inputs.
- `flush` and the final iteration on the same edge: flush wins, HI/LO unchanged.

## Configuration
- `MULDIV_SIGNED_DIV_EN` defined: op 3'd3 performs signed DIV as above; sign-fixup logic is compiled in.
- `MULDIV_SIGNED_DIV_EN` undefined: op 3'd3 executes as DIVU (unsigned, identical timing); no sign-fixup logic is present.

## Test plan
- Reset, then MULT 0xFFFF_FFFF × 0x0000_0002 with MUL_LATENCY=2 -> `busy` high 2 cycles, HI=0xFFFF_FFFF, LO=0xFFFF_FFFE, `done` pulse once.
- DIVU 100 / 7 -> `busy` high exactly 32 cycles, then LO=14, HI=2, `done`=1 for one cycle.
- DIVU 0x1234_5678 / 0 -> after 32 cycles HI=0x1234_5678, LO=0xFFFF_FFFF.
- Preload HI=LO=0xAAAA_AAAA via MTHI/MTLO, start DIVU, assert `flush` in iteration 10 -> `busy`=0 next cycle, HI/LO remain 0xAAAA_AAAA, no `done`.
- MTHI 0x55 presented during a divide -> ignored while `busy`; re-presented after `done` -> HI=0x55 one cycle later. A DIVU issued in the `done` cycle is accepted without a bubble.
- DIV 0xFFFF_FFF9 (-7) / 2:
  - with `MULDIV_SIGNED_DIV_EN`: LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
  - without it: LO=0x7FFF_FFFC, HI=1.
